mips_mult_div: RTL and testbench
================================

Name: mips_mult_div

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the MIPS ALU in the EX stage and is driven by a start/busy/done handshake, so the pipeline stalls on MFHI/MFLO while busy. It extends the ALU operation set with multi-cycle, width-generic arithmetic.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; minimum 4.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter; derived, do not override.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; accepted only when busy=0
md_op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op
a  input  WIDTH  rs operand (multiplicand / dividend / move source)
b  input  WIDTH  rt operand (multiplier / divisor)
abort  input  1  cancel the in-flight operation (exception flush)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  operation in progress
done  output  1  one-cycle pulse on the edge that HI/LO take a result

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1, md_op in 0..3: latch operands (absolute values for signed ops) and result signs, counter=0, busy=1 → CALC. Call this acceptance edge E0.
- IDLE, start=1, MTHI/MTLO: hi (or lo) <= a at the next edge. busy and done stay 0. Stay IDLE.
- IDLE, start=1, md_op 6/7: no state change.
- CALC: one iteration per cycle; multiply is radix-2 shift-add, divide is restoring. Counter increments each cycle. After WIDTH iterations → FIX.
- FIX: apply sign correction, write {hi,lo}, pulse done=1, busy=0 → IDLE. Result edge is E0+WIDTH+1.
- Latency: done high for exactly the one cycle following edge E0+WIDTH+1. busy is high for exactly WIDTH+1 cycles.
- Multiply: {hi,lo} = 2*WIDTH-bit product. MULT is signed two's complement; MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero: lo = all ones, hi = a (raw). No sign fix. Latency unchanged.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- start while busy=1: ignored, not queued.
- abort=1: FSM → IDLE, busy=0, done stays 0, hi/lo unchanged.
  - abort has priority over a start in the same cycle.
  - abort in FIX suppresses the write.
- start on the same cycle done is high: FSM is in IDLE, so the request is accepted.
- hi/lo hold their value between writes. Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
MD_DIVZERO_FLAG_EN
- Defined: adds output div_by_zero (1 bit). It is set in FIX when a DIV/DIVU had b=0. It is cleared by reset or by the next accepted multiply/divide. HI/LO results are unchanged.
- Undefined: port absent; div-by-zero behaviour otherwise identical.

Test Plan:
- MULTU, WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF, start at E0 → done after 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- MULT, a=-7 (0xFFFFFFF9), b=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6 (-42).
- DIV, a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU, a=7, b=2 → lo=3, hi=1.
- DIVU, a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234. With MD_DIVZERO_FLAG_EN, div_by_zero=1 until the next accepted op.
- MTHI a=0xA5A5A5A5, then MULT started; abort at cycle 10 → busy=0, no done, hi=0xA5A5A5A5. A start during busy changes nothing.
- reset_n pulsed low mid-CALC (async) → hi=lo=0, busy=done=0 immediately. Re-run with WIDTH=8: MULTU 0xFF*0xFF → hi=0xFE, lo=0x01 after 9 cycles.

Source files
------------

// File: rtl/mips_mult_div.sv
// rtl/mips_mult_div.sv - iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO; optional MD_DIVZERO_FLAG_EN
module mips_mult_div #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
`ifdef MD_DIVZERO_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_next;

  // p holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   opnd;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw;  // unmodified dividend, returned in HI on divide by zero
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_q, neg_r, dz;

  logic               accept_md, accept_mv;
  logic               op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum, shifted, diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Request decode and operand magnitudes; abort always wins over a new request
  always_comb begin
    accept_md = (state == IDLE) && start && !abort && !md_op[2];
    accept_mv = (state == IDLE) && start && !abort && (md_op[2:1] == 2'b10);
    op_signed = !md_op[0];
    a_neg     = op_signed && a[WIDTH-1];
    b_neg     = op_signed && b[WIDTH-1];
    abs_a     = a_neg ? ('0 - a) : a;
    abs_b     = b_neg ? ('0 - b) : b;
  end

  // One radix-2 shift-add step and one restoring-divide step, plus the final sign fix.
  // most-negative / -1 needs no special case: the magnitude quotient 2^(WIDTH-1) with
  // no negation is exactly the most-negative pattern, and the remainder is zero.
  always_comb begin
    add_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd} : '0);
    mul_step = {add_sum, p[WIDTH-1:1]};
    shifted  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    div_step = diff[WIDTH] ? {shifted[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0],    p[WIDTH-2:0], 1'b1};
    prod_fix = neg_q ? ('0 - p) : p;
    quo_fix  = neg_q ? ('0 - p[WIDTH-1:0]) : p[WIDTH-1:0];
    rem_fix  = neg_r ? ('0 - p[2*WIDTH-1:WIDTH]) : p[2*WIDTH-1:WIDTH];
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next state: WIDTH iterations in CALC, one sign-fix/write cycle in FIX
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept_md) state_next = CALC;
        CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
        FIX:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == FIX) && !abort;
    end
  end

  // Operand capture on acceptance and per-cycle iteration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p      <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (accept_md) begin
      p      <= {{WIDTH{1'b0}}, (md_op[1] ? abs_a : abs_b)};
      opnd   <= md_op[1] ? abs_b : abs_a;
      a_raw  <= a;
      cnt    <= '0;
      is_div <= md_op[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dz     <= (b == '0);
    end else if (state == CALC) begin
      p   <= is_div ? div_step : mul_step;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Architectural HI/LO: moves from IDLE, results from an unaborted FIX
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (accept_mv) begin
      if (md_op[0]) lo <= a;
      else          hi <= a;
    end else if ((state == FIX) && !abort) begin
      if (!is_div) begin
        {hi, lo} <= prod_fix;
      end else if (dz) begin
        hi <= a_raw;
        lo <= '1;
      end else begin
        hi <= rem_fix;
        lo <= quo_fix;
      end
    end
  end

`ifdef MD_DIVZERO_FLAG_EN
  // Divide-by-zero flag, held until the next accepted multiply/divide
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                      div_by_zero <= 1'b0;
    else if (accept_md)                                div_by_zero <= 1'b0;
    else if ((state == FIX) && !abort && is_div && dz) div_by_zero <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mips_mult_div.sv
// tb/tb_mips_mult_div.sv - directed bench with an arithmetic reference model for mips_mult_div
`timescale 1ns/1ps
module tb_mips_mult_div;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [2:0]   md_op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  logic         start8 = 1'b0;
  logic         abort8 = 1'b0;
  logic [2:0]   md_op8 = 3'd0;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic [7:0]   hi8, lo8;
  logic         busy8, done8;
`ifdef MD_DIVZERO_FLAG_EN
  logic         div_by_zero;
  logic         div_by_zero8;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_mult_div #(.WIDTH(W)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op), .a(a), .b(b),
    .abort(abort), .hi(hi), .lo(lo), .busy(busy), .done(done)
`ifdef MD_DIVZERO_FLAG_EN
    , .div_by_zero(div_by_zero)
`endif
  );

  mips_mult_div #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .md_op(md_op8), .a(a8), .b(b8),
    .abort(abort8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8)
`ifdef MD_DIVZERO_FLAG_EN
    , .div_by_zero(div_by_zero8)
`endif
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {div_by_zero, hi, lo}
  function automatic logic [2*W:0] model_md(input logic [2:0] op, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    logic [W-1:0]    q, r;
    sx = x;
    sy = y;
    model_md = '0;
    case (op)
      3'd0: begin
        sp = longint'(sx) * longint'(sy);
        model_md = {1'b0, sp};
      end
      3'd1: begin
        up = {32'd0, x} * {32'd0, y};
        model_md = {1'b0, up};
      end
      3'd2: begin
        if (y == 0) model_md = {1'b1, x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model_md = {1'b0, 32'd0, 32'h8000_0000};
        else begin
          q = sx / sy;
          r = sx % sy;
          model_md = {1'b0, r, q};
        end
      end
      3'd3: begin
        if (y == 0) model_md = {1'b1, x, 32'hFFFF_FFFF};
        else        model_md = {1'b0, x % y, x / y};
      end
      default: model_md = '0;
    endcase
  endfunction

  // Cycle-level expectation: remaining busy cycles, pending result, visible HI/LO/done/flag
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_done, m_dz, p_dz;
  int           m_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (abort) begin
        m_left <= 0;
      end else if (m_left == 1) begin
        m_left <= 0;
        m_hi   <= p_hi;
        m_lo   <= p_lo;
        m_done <= 1'b1;
        m_dz   <= p_dz;
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end else if (start) begin
        if (md_op <= 3'd3) begin
          {p_dz, p_hi, p_lo} <= model_md(md_op, a, b);
          m_left <= W + 1;
          m_dz   <= 1'b0;
        end else if (md_op == 3'd4) begin
          m_hi <= a;
        end else if (md_op == 3'd5) begin
          m_lo <= a;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("busy", busy, m_left > 0);
    check("done", done, m_done);
`ifdef MD_DIVZERO_FLAG_EN
    check("div_by_zero", div_by_zero, m_dz);
`endif
  end

  // Issue a multiply/divide at a negedge; return at the negedge where done is seen
  task automatic run_md(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int cycles);
    int guard;
    start = 1'b1; md_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    guard  = 0;
    while (!done && guard < 100) begin
      if (busy) cycles++;
      guard++;
      @(negedge clk);
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                      output int cycles);
    int guard;
    start8 = 1'b1; md_op8 = op; a8 = av; b8 = bv;
    @(negedge clk);
    start8 = 1'b0;
    cycles = 0;
    guard  = 0;
    while (!done8 && guard < 50) begin
      if (busy8) cycles++;
      guard++;
      @(negedge clk);
    end
    check("done8_seen", done8, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int seen;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Pin the model with hand-computed results
    run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check("multu_busy_cycles", 64'(cyc), 64'd33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // Issued on the done cycle: must be accepted
    run_md(3'd0, 32'hFFFF_FFF9, 32'd6, cyc);
    check("mult_cycles", 64'(cyc), 64'd33);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFD6);

    run_md(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    run_md(3'd3, 32'd7, 32'd2, cyc);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    run_md(3'd2, 32'd7, 32'hFFFF_FFFE, cyc);
    check("div_negdiv_lo", lo, 32'hFFFF_FFFD);
    check("div_negdiv_hi", hi, 32'd1);

    run_md(3'd3, 32'h0000_1234, 32'd0, cyc);
    check("divz_cycles", 64'(cyc), 64'd33);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'h0000_1234);
`ifdef MD_DIVZERO_FLAG_EN
    check("divz_flag_set", div_by_zero, 1'b1);
`endif
    run_md(3'd1, 32'd3, 32'd5, cyc);
    check("multu_small_lo", lo, 32'd15);
    check("multu_small_hi", hi, 32'd0);
`ifdef MD_DIVZERO_FLAG_EN
    check("divz_flag_clear", div_by_zero, 1'b0);
`endif

    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    run_md(3'd0, 32'h8000_0000, 32'h8000_0000, cyc);
    check("mult_minmin_hi", hi, 32'h4000_0000);
    check("mult_minmin_lo", lo, 32'd0);

    // Moves
    start = 1'b1; md_op = 3'd4; a = 32'hA5A5_A5A5;
    @(negedge clk);
    md_op = 3'd5; a = 32'h5A5A_5A5A;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mtlo_lo", lo, 32'h5A5A_5A5A);
    check("mt_busy", busy, 1'b0);

    // No-op codes change nothing
    start = 1'b1; md_op = 3'd6; a = 32'h1111_1111;
    @(negedge clk);
    md_op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    check("noop_busy", busy, 1'b0);

    // Abort mid-CALC, with an ignored start while busy
    start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_hi", hi, 32'hA5A5_A5A5);
    check("abort_lo", lo, 32'h5A5A_5A5A);

    // Abort beats a same-cycle move
    start = 1'b1; md_op = 3'd4; a = 32'h0; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_vs_mthi", hi, 32'hA5A5_A5A5);

    // Abort during the final write cycle suppresses the result
    start = 1'b1; md_op = 3'd1; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    check("fix_busy", busy, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("fix_abort_done", done, 1'b0);
    check("fix_abort_busy", busy, 1'b0);
    check("fix_abort_lo", lo, 32'h5A5A_5A5A);

    // Asynchronous reset in the middle of an operation
    start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("areset_hi", hi, 0);
    check("areset_lo", lo, 0);
    check("areset_busy", busy, 0);
    check("areset_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 8-bit instance
    run8(3'd1, 8'hFF, 8'hFF, cyc);
    check("w8_cycles", 64'(cyc), 64'd9);
    check("w8_hi", hi8, 8'hFE);
    check("w8_lo", lo8, 8'h01);
    run8(3'd2, 8'hF9, 8'h02, cyc);
    check("w8_div_lo", lo8, 8'hFD);
    check("w8_div_hi", hi8, 8'hFF);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
